// File: rtl/adder_arbiter_pkg.sv
// Shared defaults and FSM encoding for the round-robin shared-adder arbiter.
package adder_arb_pkg;

  localparam int unsigned W_DEF    = 32;
  localparam int unsigned NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Requester index width; never below one bit so a single-requester build stays legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between requesters, the shared adder arbiter and the result consumer.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF
) ();

  localparam int unsigned DW  = 2 * W;
  localparam int unsigned IDW = id_width(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_wide;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [DW-1:0]      resp_sum;
  logic               resp_cout;

  modport master (
    output req_valid, req_wide, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

  modport slave (
    input  req_valid, req_wide, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

endinterface

// File: rtl/adder_arbiter_add_core.sv
// Combinational W-bit ripple adder shared by both halves of every operation.
module add_core #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to one W-bit adder;
// 2W-bit adds take a second pass through the same adder.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF
) (
  input logic            clk,
  input logic            rst,
  adder_arbiter_if.slave bus
);

  localparam int unsigned DW  = 2 * W;
  localparam int unsigned IDW = id_width(NREQ);

  state_t          state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic [NREQ-1:0] ready_c;
  logic [IDW-1:0]  id_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic            wide_q;
  logic [W-1:0]    sum_lo;
  logic            carry_q;
  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic [W-1:0]    add_sum;
  logic            add_cin;
  logic            add_cout;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [DW-1:0]   resp_sum_q;
  logic            resp_cout_q;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
    return IDW'((32'(base) + k) % NREQ);
  endfunction

  // First valid requester strictly after last_grant, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!gnt_found && bus.req_valid[rr_idx(last_grant, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(last_grant, k);
      end
    end
  end

  always_comb begin
    ready_c = '0;
    if (!rst && state == IDLE && gnt_found) ready_c[gnt_idx] = 1'b1;
  end

  // Low pass adds the bottom halves with cin=0; high pass chains the stored carry.
  assign add_a   = (state == HI) ? a_q[DW-1:W] : a_q[W-1:0];
  assign add_b   = (state == HI) ? b_q[DW-1:W] : b_q[W-1:0];
  assign add_cin = (state == HI) && carry_q;

  add_core #(.W(W)) u_add_core (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      wide_q       <= 1'b0;
      sum_lo       <= '0;
      carry_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            last_grant <= gnt_idx;
            id_q       <= gnt_idx;
            a_q        <= bus.req_a[gnt_idx*DW +: DW];
            b_q        <= bus.req_b[gnt_idx*DW +: DW];
            wide_q     <= bus.req_wide[gnt_idx];
            state      <= LO;
          end
        end
        LO: begin
          sum_lo  <= add_sum;
          carry_q <= add_cout;
          if (wide_q) begin
            state <= HI;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_sum_q   <= {{W{1'b0}}, add_sum};
            resp_cout_q  <= add_cout;
          end
        end
        HI: begin
          carry_q      <= add_cout;
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_id_q    <= id_q;
          resp_sum_q   <= {add_sum, sum_lo};
          resp_cout_q  <= add_cout;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_cout  = resp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: stimulus pushes expected responses, a monitor pops and checks them.
module tb_adder_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned DW   = 2 * W;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] sum;
    logic        cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [31:0] aa [NREQ] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] bb [NREQ] = '{32'h00000100, 32'h00000200, 32'h00000300, 32'h00000400};
  logic [31:0] ss [NREQ] = '{32'h11111211, 32'h22222422, 32'h33333633, 32'h44444844};

  adder_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [63:0] s, input logic c);
    exp_t e;
    e.id   = 2'(id);
    e.sum  = s;
    e.cout = c;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int id, input logic wide, input logic [63:0] a, input logic [63:0] b);
    bus.req_valid[id]         = 1'b1;
    bus.req_wide[id]          = wide;
    bus.req_a[id*DW +: DW]    = a;
    bus.req_b[id*DW +: DW]    = b;
  endtask

  // Single requester transaction with grant and latency checks.
  task automatic run_op(input int id, input logic wide, input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] s, input logic c);
    int got;
    @(posedge clk); #1;
    drive_req(id, wide, a, b);
    @(negedge clk);
    chk("grant", 64'(bus.req_ready), 64'(1 << id));
    push(id, s, c);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    got = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = cyc;
        break;
      end
    end
    chk("latency", 64'(got), 64'(lat));
    @(posedge clk);
  endtask

  task automatic drain();
    for (int cyc = 0; cyc < 40 && sb.size() != 0; cyc++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
  endtask

  // Response monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: got id %0d sum 0x%0h, expected no response at %0t",
                   bus.resp_id, bus.resp_sum, $time);
        end else begin
          e = sb.pop_front();
          chk("resp_id",   64'(bus.resp_id),   64'(e.id));
          chk("resp_sum",  bus.resp_sum,       e.sum);
          chk("resp_cout", 64'(bus.resp_cout), 64'(e.cout));
        end
      end
    end
  end

  initial begin
    int e;
    int found;
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_wide   = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  64'(bus.req_ready),  64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id",    64'(bus.resp_id),    64'd0);
    chk("rst_resp_sum",   bus.resp_sum,        64'd0);
    chk("rst_resp_cout",  64'(bus.resp_cout),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Narrow and wide carry cases, plus narrow op ignoring upper halves.
    run_op(0, 1'b0, 64'hFFFFFFFF, 64'h1, 2, 64'h0, 1'b1);
    run_op(1, 1'b1, 64'h00000000_FFFFFFFF, 64'h1, 3, 64'h00000001_00000000, 1'b0);
    run_op(2, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3, 64'hFFFFFFFF_FFFFFFFE, 1'b1);
    run_op(3, 1'b0, 64'hDEADBEEF_12345678, 64'h11111111_87654321, 2, 64'h00000000_99999999, 1'b0);

    // All requesters continuously valid: grants rotate 0,1,2,3,0.
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) drive_req(i, 1'b0, {32'hFFFFFFFF, aa[i]}, {32'hFFFFFFFF, bb[i]});
    for (int g = 0; g < 5; g++) begin
      e = g % NREQ;
      found = 0;
      for (int cyc = 0; cyc < 10 && found == 0; cyc++) begin
        @(negedge clk);
        if (bus.req_ready != '0) found = 1;
      end
      chk("rr_grant", 64'(bus.req_ready), 64'(1 << e));
      push(e, {32'h0, ss[e]}, 1'b0);
      @(posedge clk); #1;
      if (g == 4) bus.req_valid = '0;
    end
    drain();

    // Consumer stall: response held, waiting requester not granted until after handshake.
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    drive_req(1, 1'b0, 64'h5, 64'h7);
    drive_req(2, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF);
    @(negedge clk);
    chk("stall_grant", 64'(bus.req_ready), 64'h2);
    push(1, 64'hC, 1'b0);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid) break;
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      chk("stall_valid", 64'(bus.resp_valid), 64'd1);
      chk("stall_sum",   bus.resp_sum,        64'hC);
      chk("stall_ready", 64'(bus.req_ready),  64'd0);
      if (cyc < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("handshake_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("post_accept", 64'(bus.req_ready), 64'h4);
    push(2, 64'h00000000_FFFFFFFE, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // Reset during the high pass of a wide op discards it.
    @(posedge clk); #1;
    drive_req(2, 1'b1, 64'h00000001_00000001, 64'h00000002_00000002);
    @(negedge clk);
    chk("abort_grant", 64'(bus.req_ready), 64'h4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready",  64'(bus.req_ready),  64'd0);
    chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("mid_rst_resp_id",    64'(bus.resp_id),    64'd0);
    chk("mid_rst_resp_sum",   bus.resp_sum,        64'd0);
    chk("mid_rst_resp_cout",  64'(bus.resp_cout),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1, 1'b0, 64'h7FFFFFFF, 64'h1);
    drive_req(3, 1'b0, 64'h5, 64'h5);
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.req_ready), 64'h2);
    push(1, 64'h00000000_80000000, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
    repeat (6) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder.
REQ-002 Parameter W, default 32, adder datapath width; operands are 2*W wide.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept strobe, at most one bit set.
REQ-007 req_wide  input  NREQ  per-requester op size, 1 = 2*W-bit add, 0 = W-bit add.
REQ-008 req_a  input  NREQ*2*W  operand A, requester i in slice [i*2W +: 2W].
REQ-009 req_b  input  NREQ*2*W  operand B, same packing as req_a.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 resp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-013 resp_sum  output  2*W  sum.
REQ-014 resp_cout  output  1  carry out of the operation's most significant bit.

Function
REQ-015 FSM states IDLE, LO, HI, RESP; a single W-bit adder instance is used for every pass.
REQ-016 IDLE: if any req_valid is set, the winner is the first set bit searching upward (with wrap) from last_grant+1; req_ready[winner]=1 that cycle, operands/wide/id latched, and the next state is LO.
REQ-017 req_ready is 0 in LO, HI and RESP, and in IDLE when no valid is set.
REQ-018 last_grant updates to the winner on accept only, so a continuously requesting requester is served at most once per NREQ grants while others wait.
REQ-019 LO: adder computes A[W-1:0]+B[W-1:0] with cin=0; result registered into sum[W-1:0], carry registered; next is HI if wide, else RESP.
REQ-020 HI: adder computes A[2W-1:W]+B[2W-1:W]+registered LO carry into sum[2W-1:W]; carry registered; next is RESP.
REQ-021 Narrow op: resp_sum[2W-1:W]=0, resp_cout = carry out of bit W-1; upper operand halves ignored.
REQ-022 Wide op: resp_cout = carry out of bit 2W-1; arithmetic is modulo 2^(2W).
REQ-023 RESP: resp_valid=1 and resp_id/resp_sum/resp_cout stable until resp_ready; on resp_ready, next is IDLE.
REQ-024 Latency, accept edge to resp_valid: narrow 2 cycles, wide 3 cycles; new accept no earlier than the cycle after the response handshake.
REQ-025 Requesters hold req_valid and operands until req_ready; deasserting valid before grant simply removes the request (no error).
REQ-026 resp_valid is 0 outside RESP; resp_sum/resp_id/resp_cout hold their last values outside RESP.

Reset
REQ-027 rst asserted at any time, including mid-operation, forces IDLE immediately; the in-flight operation is discarded without a response.
REQ-028 Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, last_grant=NREQ-1 (requester 0 wins first).

Structure
REQ-029 Shared package adder_arb_pkg holds the W and NREQ defaults and the FSM state enumeration.
REQ-030 Sub-module add_core: combinational W-bit adder (a, b, cin -> sum, cout), instantiated exactly once.
REQ-031 Round-robin selection is combinational from req_valid and last_grant; all other outputs are registered.

Verification
REQ-032 Reset, req0 narrow A=0xFFFFFFFF, B=1 -> req_ready[0] on cycle 0, resp_valid on cycle 2, resp_sum=0, resp_cout=1, resp_id=0.
REQ-033 req1 wide A=0x00000000_FFFFFFFF, B=1 -> resp_valid on cycle 3, resp_sum=0x00000001_00000000, resp_cout=0; A=B=0xFFFFFFFF_FFFFFFFF -> resp_sum=0xFFFFFFFF_FFFFFFFE, resp_cout=1.
REQ-034 All four requesters valid continuously -> grant order 0,1,2,3,0, one grant per response handshake.
REQ-035 resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_sum stable, no req_ready asserted; accept occurs the cycle after resp_ready.
REQ-036 rst pulsed during HI of a wide op -> no response, all outputs 0 next cycle, next grant goes to lowest-index valid requester.
